// File: rtl/dco_nco_array_if.sv
// Tuning-code write port for dco_nco_array: valid/ready handshake carrying
// target channel, code and output mode.
interface dco_nco_array_if #(
   parameter int NCH    = 2,
   parameter int CODE_W = 8
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic              code_valid;
   logic              code_ready;
   logic [CH_W-1:0]   code_ch;
   logic [CODE_W-1:0] code_data;
   logic              code_mode;

   modport master (
      output code_valid, code_ch, code_data, code_mode,
      input  code_ready
   );

   modport slave (
      input  code_valid, code_ch, code_data, code_mode,
      output code_ready
   );
endinterface

// File: rtl/dco_nco_array.sv
// Multi-channel phase-accumulator DCO; code writes are shadowed and applied
// only at the channel's wrap (or when idle / disabled) so periods never truncate.
module dco_nco_array #(
   parameter int NCH    = 2,
   parameter int CODE_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   dco_nco_array_if.slave bus,
   output logic [NCH-1:0] dco_out,
   output logic [NCH-1:0] wrap_pulse
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0][ACC_W-1:0]  acc_q, acc_d;
   logic [NCH-1:0][CODE_W-1:0] code_q, code_d;
   logic [NCH-1:0][CODE_W-1:0] shadow_code_q, shadow_code_d;
   logic [NCH-1:0]             mode_q, mode_d;
   logic [NCH-1:0]             shadow_mode_q, shadow_mode_d;
   logic [NCH-1:0]             pend_q, pend_d;
   logic [NCH-1:0]             tog_q, tog_d;
   logic [NCH-1:0]             wrap_q, wrap_d;
   logic                       code_ready;
   logic                       wr;
   logic [CH_W-1:0]            wr_ch;

   assign wr_ch = bus.code_ch;

   // Out-of-range channel numbers match no entry and leave ready low.
   always_comb begin
      code_ready = 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (wr_ch == CH_W'(c)) code_ready = ~pend_q[c];
      end
   end

   assign bus.code_ready = code_ready;
   assign wr             = bus.code_valid & code_ready;

   always_comb begin
      logic [ACC_W:0] sum;
      logic           run;
      logic           carry;
      acc_d         = acc_q;
      code_d        = code_q;
      mode_d        = mode_q;
      shadow_code_d = shadow_code_q;
      shadow_mode_d = shadow_mode_q;
      pend_d        = pend_q;
      tog_d         = tog_q;
      wrap_d        = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         run   = en && (code_q[c] != '0);
         sum   = {1'b0, acc_q[c]} + (ACC_W+1)'(code_q[c]);
         carry = run & sum[ACC_W];
         acc_d[c]  = run ? sum[ACC_W-1:0] : '0;
         tog_d[c]  = en & (tog_q[c] ^ carry);
         wrap_d[c] = carry;
         // The carrying add above still used the old code; the new one starts next cycle.
         if (pend_q[c] && (carry || (code_q[c] == '0) || !en)) begin
            code_d[c] = shadow_code_q[c];
            mode_d[c] = shadow_mode_q[c];
            pend_d[c] = 1'b0;
         end
         if (wr && (wr_ch == CH_W'(c))) begin
            shadow_code_d[c] = bus.code_data;
            shadow_mode_d[c] = bus.code_mode;
            pend_d[c]        = 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < NCH; c++) begin
         dco_out[c] = mode_q[c] ? tog_q[c] : acc_q[c][ACC_W-1];
      end
   end

   assign wrap_pulse = wrap_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q         <= '0;
         code_q        <= '0;
         mode_q        <= '0;
         shadow_code_q <= '0;
         shadow_mode_q <= '0;
         pend_q        <= '0;
         tog_q         <= '0;
         wrap_q        <= '0;
      end else begin
         acc_q         <= acc_d;
         code_q        <= code_d;
         mode_q        <= mode_d;
         shadow_code_q <= shadow_code_d;
         shadow_mode_q <= shadow_mode_d;
         pend_q        <= pend_d;
         tog_q         <= tog_d;
         wrap_q        <= wrap_d;
      end
   end
endmodule
